// File: rtl/avg_pix_filter_if.sv
// -----------------------------------------------------------------------------
// avg_pix_filter_if
//   Sample/result bundle for the 3x3 neighbourhood combiner.
//
//   master : the pixel source. It drives in_valid, the neighbours a..h and the
//            centre pixel orig, and it receives new_color/out_valid.
//   slave  : the filter. It receives the sample and drives the registered
//            result.
//
//   Parameter DATA_W : pixel width in bits for every pixel field.
// -----------------------------------------------------------------------------
interface avg_pix_filter_if #(
   parameter int DATA_W = 8
);
   logic              in_valid;
   logic [DATA_W-1:0] a;
   logic [DATA_W-1:0] b;
   logic [DATA_W-1:0] c;
   logic [DATA_W-1:0] d;
   logic [DATA_W-1:0] e;
   logic [DATA_W-1:0] f;
   logic [DATA_W-1:0] g;
   logic [DATA_W-1:0] h;
   logic [DATA_W-1:0] orig;
   logic [DATA_W-1:0] new_color;
   logic              out_valid;

   modport master (
      output in_valid, a, b, c, d, e, f, g, h, orig,
      input  new_color, out_valid
   );

   modport slave (
      input  in_valid, a, b, c, d, e, f, g, h, orig,
      output new_color, out_valid
   );
endinterface

// File: rtl/avg_pix_filter.sv
// -----------------------------------------------------------------------------
// avg_pix_filter
//   Registered 3x3 neighbourhood pixel combiner. Sums the centre pixel and its
//   eight neighbours, divides by 2^SHIFT (plain right shift, truncating) and
//   registers the result with one cycle of latency, one sample per cycle.
//
//   Ports:
//     clk    : rising-edge clock
//     rst_n  : asynchronous active-low reset (clears new_color and out_valid)
//     bus    : avg_pix_filter_if.slave
//                in_valid, a..h, orig -> sample in
//                new_color, out_valid -> registered result out
//
//   Parameters:
//     DATA_W : pixel width (must match the interface instance)
//     SHIFT  : right shift applied to the nine-value sum
//
//   Build option:
//     AVG_PIX_SAT_EN defined   -> results above 2^DATA_W-1 clamp to the maximum
//     AVG_PIX_SAT_EN undefined -> the low DATA_W bits are kept (wrap)
// -----------------------------------------------------------------------------
module avg_pix_filter #(
   parameter int DATA_W = 8,
   parameter int SHIFT  = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   avg_pix_filter_if.slave    bus
);
   // Four extra bits hold nine DATA_W-bit values without overflow.
   localparam int SUM_W = DATA_W + 4;

   logic [SUM_W-1:0]  sum;
   logic [SUM_W-1:0]  shifted;
   logic [DATA_W-1:0] result;

   always_comb begin
      sum = SUM_W'(bus.a) + SUM_W'(bus.b) + SUM_W'(bus.c)
          + SUM_W'(bus.d) + SUM_W'(bus.e) + SUM_W'(bus.f)
          + SUM_W'(bus.g) + SUM_W'(bus.h) + SUM_W'(bus.orig);
      shifted = sum >> SHIFT;
   end

`ifdef AVG_PIX_SAT_EN
   // Any set bit above the pixel width means the value is out of range.
   always_comb begin
      result = DATA_W'(shifted);
      if ((shifted >> DATA_W) != '0)
         result = '1;
   end
`else
   always_comb begin
      result = DATA_W'(shifted);
   end
`endif

   // new_color only loads on accepted samples, so it holds its value through
   // idle cycles; out_valid follows in_valid one cycle later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.new_color <= '0;
         bus.out_valid <= 1'b0;
      end else begin
         bus.out_valid <= bus.in_valid;
         if (bus.in_valid)
            bus.new_color <= result;
      end
   end
endmodule

// File: tb/tb_avg_pix_filter.sv
module tb_avg_pix_filter;
   logic clk;
   logic rst_n;
   int   n_pass;
   int   n_total;
   logic [7:0] hold_color;

   avg_pix_filter_if #(.DATA_W(8)) bus ();

   avg_pix_filter #(.DATA_W(8), .SHIFT(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain arithmetic on the nine values.
   function automatic logic [7:0] ref_avg(input int v[9]);
      int s;
      s = 0;
      foreach (v[i]) s += v[i];
      s = s / 4;
`ifdef AVG_PIX_SAT_EN
      if (s > 255) s = 255;
`else
      s = s % 256;
`endif
      return 8'(s);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   task automatic drive(input logic vld, input int v[9]);
      bus.in_valid = vld;
      bus.a = 8'(v[0]); bus.b = 8'(v[1]); bus.c = 8'(v[2]); bus.d = 8'(v[3]);
      bus.e = 8'(v[4]); bus.f = 8'(v[5]); bus.g = 8'(v[6]); bus.h = 8'(v[7]);
      bus.orig = 8'(v[8]);
   endtask

   initial begin
      int z[9], p1[9], p2[9], ff[9], r[9];
      logic [7:0] exp_c;
      logic vld;
      logic [7:0] exp_sat;
      n_pass = 0;
      n_total = 0;
      z  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
      p1 = '{8'h3F, 8'h7F, 8'h3F, 8'h7F, 8'h3F, 8'h7F, 8'h3F, 8'h7F, 8'hFF};
      p2 = '{8'h1F, 8'h3F, 8'h1F, 8'h3F, 8'h1F, 8'h3F, 8'h1F, 8'h3F, 8'h7F};
      ff = '{255, 255, 255, 255, 255, 255, 255, 255, 255};
`ifdef AVG_PIX_SAT_EN
      exp_sat = 8'hFF;
`else
      exp_sat = 8'h3D;
`endif

      // Reset state
      rst_n = 1'b0;
      drive(1'b0, z);
      #12;
      check("reset_color", 32'(bus.new_color), 32'h0);
      check("reset_valid", 32'(bus.out_valid), 32'h0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      check("idle_after_reset_valid", 32'(bus.out_valid), 32'h0);
      check("idle_after_reset_color", 32'(bus.new_color), 32'h0);

      // Directed samples
      @(negedge clk); drive(1'b1, z);
      @(posedge clk); #1;
      check("zeros_color", 32'(bus.new_color), 32'h00);
      check("zeros_valid", 32'(bus.out_valid), 32'h1);
      @(negedge clk); drive(1'b1, p1);
      @(posedge clk); #1;
      check("p1_color", 32'(bus.new_color), 32'hFD);
      check("p1_valid", 32'(bus.out_valid), 32'h1);
      @(negedge clk); drive(1'b1, p2);
      @(posedge clk); #1;
      check("p2_color", 32'(bus.new_color), 32'h7D);
      @(negedge clk); drive(1'b1, ff);
      @(posedge clk); #1;
      check("all_ff_color", 32'(bus.new_color), 32'(exp_sat));

      // Back-to-back then idle: results track each sample, then hold
      @(negedge clk); drive(1'b1, p2);
      @(posedge clk); #1;
      check("b2b_0_color", 32'(bus.new_color), 32'h7D);
      check("b2b_0_valid", 32'(bus.out_valid), 32'h1);
      @(negedge clk); drive(1'b1, p1);
      @(posedge clk); #1;
      check("b2b_1_color", 32'(bus.new_color), 32'hFD);
      check("b2b_1_valid", 32'(bus.out_valid), 32'h1);
      @(negedge clk); drive(1'b0, z);
      @(posedge clk); #1;
      check("idle_valid", 32'(bus.out_valid), 32'h0);
      check("idle_hold_color", 32'(bus.new_color), 32'hFD);
      @(posedge clk); #1;
      check("idle_hold_color2", 32'(bus.new_color), 32'hFD);

      // Asynchronous reset between clock edges
      @(negedge clk); drive(1'b1, p2);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      check("async_rst_color", 32'(bus.new_color), 32'h0);
      check("async_rst_valid", 32'(bus.out_valid), 32'h0);
      @(posedge clk); #1;
      check("in_rst_color", 32'(bus.new_color), 32'h0);
      check("in_rst_valid", 32'(bus.out_valid), 32'h0);
      @(negedge clk); rst_n = 1'b1; drive(1'b1, p1);
      @(posedge clk); #1;
      check("post_rst_color", 32'(bus.new_color), 32'hFD);
      check("post_rst_valid", 32'(bus.out_valid), 32'h1);

      // Randomized traffic, skewed toward large pixels to hit the overflow path
      hold_color = 8'hFD;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         vld = 1'($urandom_range(0, 3) != 0);
         for (int i = 0; i < 9; i++)
            r[i] = (k % 3 == 0) ? int'($urandom_range(150, 255)) : int'($urandom_range(0, 255));
         drive(vld, r);
         exp_c = vld ? ref_avg(r) : hold_color;
         hold_color = exp_c;
         @(posedge clk); #1;
         check($sformatf("rand%0d_valid", k), 32'(bus.out_valid), 32'(vld));
         check($sformatf("rand%0d_color", k), 32'(bus.new_color), 32'(exp_c));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
